// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkg
// Description : Shared types for the AXI-Stream setpoint path (slew limiter
//               state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkg;

  // Slew limiter control state, two-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2
  } slew_state_t;

endpackage : axis_pkg
`default_nettype wire

// File: rtl/slew_step.sv
`default_nettype none
// ============================================================================
// Module      : slew_step
// Description : Combinational single-step clamp. Moves i_cur toward i_tgt by
//               at most i_step; lands exactly on i_tgt when within reach so
//               the result never overshoots.
// Revision    : 1.0 - initial release
// ============================================================================
module slew_step
  import axis_pkg::*;
#(
  parameter int W  = 32,
  parameter int SW = 16
) (
  input  logic [W-1:0]  i_cur,
  input  logic [W-1:0]  i_tgt,
  input  logic [SW-1:0] i_step,
  output logic [W-1:0]  o_next_cur
);

  // One extra bit keeps tgt - cur exact across the full signed range.
  logic [W:0]   w_diff;
  logic [W:0]   w_mag;
  logic [W:0]   w_step_wide;
  logic [W-1:0] w_step_n;
  logic         w_within;

  assign w_diff      = {i_tgt[W-1], i_tgt} - {i_cur[W-1], i_cur};
  assign w_mag       = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
  assign w_step_wide = {{(W+1-SW){1'b0}}, i_step};
  assign w_within    = (w_mag <= w_step_wide);

  // Step zero-extended to sample width; the replication is empty when SW == W.
  generate
    if (SW < W) begin : g_step_ext
      assign w_step_n = {{(W-SW){1'b0}}, i_step};
    end else begin : g_step_full
      assign w_step_n = i_step[W-1:0];
    end
  endgenerate

  // When out of reach the true result lies strictly between cur and tgt, so
  // the W-bit add/subtract below can never wrap.
  always_comb begin
    o_next_cur = i_tgt;
    if (!w_within) begin
      if (w_diff[W]) begin
        o_next_cur = i_cur - w_step_n;
      end else begin
        o_next_cur = i_cur + w_step_n;
      end
    end
  end

endmodule : slew_step
`default_nettype wire

// File: rtl/axis_slew_limiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_slew_limiter
// Description : Rate-limited setpoint follower. Latches the incoming target
//               and emits a signed AXI-Stream sample stream that walks toward
//               it by at most cfg_step per beat, one beat per cfg_prescale+1
//               cycles. Backpressure stalls the ramp without dropping beats.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_slew_limiter
  import axis_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int STEP_WIDTH       = 16,
  parameter int PRESCALE_WIDTH   = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [STEP_WIDTH-1:0]       cfg_step,
  input  logic [PRESCALE_WIDTH-1:0]   cfg_prescale,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        sts_busy,
  output logic                        sts_at_target
);

  logic [AXIS_TDATA_WIDTH-1:0] r_tgt;
  logic                        r_have_target;
  logic [AXIS_TDATA_WIDTH-1:0] r_cur;
  logic                        r_m_valid;
  logic [PRESCALE_WIDTH-1:0]   r_cnt;
  slew_state_t                 r_state;
  slew_state_t                 w_next_state;
  logic [AXIS_TDATA_WIDTH-1:0] w_next_cur;
  logic                        w_equal;
  logic                        w_slot_free;
  logic                        w_tick;

  assign w_equal     = (r_cur == r_tgt);
  assign w_slot_free = !r_m_valid || m_axis_tready;
  assign w_tick      = r_have_target && (r_cnt == '0) && w_slot_free;

  slew_step #(
    .W  (AXIS_TDATA_WIDTH),
    .SW (STEP_WIDTH)
  ) u_slew_step (
    .i_cur      (r_cur),
    .i_tgt      (r_tgt),
    .i_step     (cfg_step),
    .o_next_cur (w_next_cur)
  );

  // Target register: last write wins; a target, once seen, persists until reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_tgt         <= '0;
      r_have_target <= 1'b0;
    end else if (s_axis_tvalid) begin
      r_tgt         <= s_axis_tdata;
      r_have_target <= 1'b1;
    end
  end

  // Beat generator: a tick advances cur and reloads the spacing counter;
  // otherwise the counter runs down and an accepted beat is retired.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cur     <= '0;
      r_m_valid <= 1'b0;
      r_cnt     <= '0;
    end else if (w_tick) begin
      r_cur     <= w_next_cur;
      r_m_valid <= 1'b1;
      r_cnt     <= cfg_prescale;
    end else begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - PRESCALE_WIDTH'(1);
      end
      if (m_axis_tready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state follows the registered cur/tgt comparison once a target exists.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_have_target) begin
          w_next_state = w_equal ? ST_HOLD : ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (w_equal) begin
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!w_equal) begin
          w_next_state = ST_RAMP;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign s_axis_tready = 1'b1;
  assign m_axis_tdata  = r_cur;
  assign m_axis_tvalid = r_m_valid;
  assign sts_busy      = (r_state == ST_RAMP);
  assign sts_at_target = (r_state == ST_HOLD);

endmodule : axis_slew_limiter
`default_nettype wire

// File: tb/tb_axis_slew_limiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_slew_limiter
// Description : Self-checking bench for axis_slew_limiter. Expected beats are
//               produced by a reference step model into a queue; accepted
//               output beats are captured by a monitor and compared in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_slew_limiter;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic [31:0]        cfg_step;
  logic [15:0]        cfg_prescale;
  logic signed [31:0] s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  logic signed [31:0] m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               busy;
  logic               at_tgt;

  int                 n_cmp = 0;
  int                 n_err = 0;
  int                 cyc   = 0;
  logic signed [31:0] exp_q[$];
  logic signed [31:0] obs_data[$];
  int                 obs_cyc[$];

  axis_slew_limiter #(
    .AXIS_TDATA_WIDTH (32),
    .STEP_WIDTH       (32),
    .PRESCALE_WIDTH   (16)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_step      (cfg_step),
    .cfg_prescale  (cfg_prescale),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .sts_busy      (busy),
    .sts_at_target (at_tgt)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Capture every accepted beat, sampled mid-cycle.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      obs_data.push_back(m_tdata);
      obs_cyc.push_back(cyc);
    end
  end

  // Reference: move cur toward tgt by at most step, landing exactly when in reach.
  function automatic logic signed [31:0] model_next(input logic signed [31:0] cur,
                                                    input logic signed [31:0] tgt,
                                                    input longint step);
    longint c, t, d, m;
    c = cur;
    t = tgt;
    d = t - c;
    m = (d < 0) ? -d : d;
    if (m <= step) return tgt;
    if (d < 0) return 32'(c - step);
    return 32'(c + step);
  endfunction

  task automatic step_cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    step_cyc();
    step_cyc();
    aresetn = 1'b1;
    step_cyc();
    obs_data.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int t = 0; t < budget && obs_data.size() < n; t++) step_cyc();
  endtask

  task automatic test_reset();
    aresetn      = 1'b0;
    s_tvalid     = 1'b1;
    s_tdata      = 32'sd1234;
    m_tready     = 1'b1;
    cfg_step     = 32'd10;
    cfg_prescale = 16'd0;
    step_cyc();
    step_cyc();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", m_tvalid); end
    n_cmp++; if (m_tdata !== 32'sd0) begin n_err++; $display("FAIL rst_data got %0d want 0", m_tdata); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (at_tgt !== 1'b0) begin n_err++; $display("FAIL rst_at_target got %b want 0", at_tgt); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rst_tready got %b want 1", s_tready); end
    s_tvalid = 1'b0;
    aresetn  = 1'b1;
    for (int i = 0; i < 5; i++) step_cyc();
    n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL idle_no_beat got %b want 0", m_tvalid); end
    n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL idle_tready got %b want 1", s_tready); end
  endtask

  task automatic test_basic_ramp();
    int k0;
    logic signed [31:0] c;
    logic v_h[9];
    logic b_h[9];
    logic a_h[9];
    logic signed [31:0] d_h[9];
    do_reset();
    cfg_step = 32'd30; cfg_prescale = 16'd0;
    c = 0;
    for (int i = 0; i < 5; i++) begin c = model_next(c, 32'sd100, 30); exp_q.push_back(c); end
    k0 = cyc;
    s_tdata = 32'sd100; s_tvalid = 1'b1;
    for (int i = 1; i < 9; i++) begin
      step_cyc();
      s_tvalid = 1'b0;
      v_h[i] = m_tvalid; b_h[i] = busy; a_h[i] = at_tgt; d_h[i] = m_tdata;
    end
    n_cmp++; if (v_h[1] !== 1'b0) begin n_err++; $display("FAIL lat_early_valid got %b want 0", v_h[1]); end
    n_cmp++; if (v_h[2] !== 1'b1 || d_h[2] !== 32'sd30) begin n_err++; $display("FAIL lat_first_beat got v=%b d=%0d want v=1 d=30", v_h[2], d_h[2]); end
    n_cmp++; if (d_h[5] !== 32'sd100 || b_h[5] !== 1'b1 || a_h[5] !== 1'b0) begin n_err++; $display("FAIL sts_at_final_beat got d=%0d busy=%b at=%b want d=100 busy=1 at=0", d_h[5], b_h[5], a_h[5]); end
    n_cmp++; if (b_h[6] !== 1'b0 || a_h[6] !== 1'b1) begin n_err++; $display("FAIL sts_after_final got busy=%b at=%b want busy=0 at=1", b_h[6], a_h[6]); end
    wait_beats(5, 50);
    n_cmp++; if (obs_cyc.size() == 0 || obs_cyc[0] - k0 !== 2) begin n_err++; $display("FAIL basic_latency got %0d want 2", (obs_cyc.size() == 0) ? -1 : obs_cyc[0] - k0); end
    for (int i = 0; i < 5; i++) begin
      logic signed [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_data.size() == 0) begin n_err++; $display("FAIL basic_beat%0d got none (timeout) want %0d", i, e); end
      else begin
        logic signed [31:0] o;
        o = obs_data.pop_front();
        if (o !== e) begin n_err++; $display("FAIL basic_beat%0d got %0d want %0d", i, o, e); end
      end
    end
  endtask

  task automatic test_prescale();
    int k0;
    int cy[4];
    logic signed [31:0] c;
    do_reset();
    cfg_step = 32'd20; cfg_prescale = 16'd3;
    c = 0;
    for (int i = 0; i < 4; i++) begin c = model_next(c, -32'sd50, 20); exp_q.push_back(c); end
    k0 = cyc;
    s_tdata = -32'sd50; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    wait_beats(4, 100);
    for (int i = 0; i < 4; i++) begin
      logic signed [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_data.size() == 0) begin n_err++; cy[i] = -100; $display("FAIL presc_beat%0d got none (timeout) want %0d", i, e); end
      else begin
        logic signed [31:0] o;
        o = obs_data.pop_front();
        cy[i] = obs_cyc.pop_front();
        if (o !== e) begin n_err++; $display("FAIL presc_beat%0d got %0d want %0d", i, o, e); end
      end
    end
    n_cmp++; if (cy[0] - k0 !== 2) begin n_err++; $display("FAIL presc_latency got %0d want 2", cy[0] - k0); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (cy[i] - cy[i-1] !== 4) begin n_err++; $display("FAIL presc_spacing%0d got %0d want 4", i, cy[i] - cy[i-1]); end
    end
  endtask

  task automatic test_backpressure();
    bit found;
    logic signed [31:0] c;
    do_reset();
    cfg_step = 32'd100; cfg_prescale = 16'd0;
    c = 0;
    for (int i = 0; i < 5; i++) begin c = model_next(c, 32'sd1000, 100); exp_q.push_back(c); end
    s_tdata = 32'sd1000; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      if (m_tvalid && m_tdata == 32'sd300) found = 1'b1; else step_cyc();
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL bp_reach300 got timeout want beat 300"); end
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (m_tdata !== 32'sd300 || m_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_stall%0d got d=%0d v=%b want d=300 v=1", i, m_tdata, m_tvalid); end
      step_cyc();
    end
    m_tready = 1'b1;
    wait_beats(5, 50);
    for (int i = 0; i < 5; i++) begin
      logic signed [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_data.size() == 0) begin n_err++; $display("FAIL bp_beat%0d got none (timeout) want %0d", i, e); end
      else begin
        logic signed [31:0] o;
        o = obs_data.pop_front();
        if (o !== e) begin n_err++; $display("FAIL bp_beat%0d got %0d want %0d", i, o, e); end
      end
    end
  endtask

  // Walk to a new target from the current held value; the two beats already
  // in flight when the target is written still carry the old value.
  task automatic extreme_leg(input logic signed [31:0] from_v, input logic signed [31:0] to_v,
                             input logic [31:0] stp, input string nm);
    logic signed [31:0] c;
    int n;
    exp_q.delete();
    exp_q.push_back(from_v);
    exp_q.push_back(from_v);
    c = from_v;
    for (int g = 0; g < 64 && c != to_v; g++) begin c = model_next(c, to_v, longint'(stp)); exp_q.push_back(c); end
    n = exp_q.size();
    obs_data.delete();
    obs_cyc.delete();
    cfg_step = stp;
    s_tdata  = to_v; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    wait_beats(n, 200);
    for (int i = 0; i < n; i++) begin
      logic signed [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_data.size() == 0) begin n_err++; $display("FAIL %s_beat%0d got none (timeout) want %0d", nm, i, e); end
      else begin
        logic signed [31:0] o;
        o = obs_data.pop_front();
        if (o !== e) begin n_err++; $display("FAIL %s_beat%0d got %0d want %0d", nm, i, o, e); end
      end
    end
  endtask

  task automatic test_extremes();
    logic signed [31:0] c;
    int n;
    do_reset();
    cfg_step = 32'h7000_0000; cfg_prescale = 16'd0;
    c = 0;
    for (int g = 0; g < 64 && c != 32'sh7FFF_FFFF; g++) begin c = model_next(c, 32'sh7FFF_FFFF, 64'h7000_0000); exp_q.push_back(c); end
    n = exp_q.size();
    s_tdata = 32'sh7FFF_FFFF; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    wait_beats(n, 100);
    for (int i = 0; i < n; i++) begin
      logic signed [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_data.size() == 0) begin n_err++; $display("FAIL ext_up_beat%0d got none (timeout) want %0d", i, e); end
      else begin
        logic signed [31:0] o;
        o = obs_data.pop_front();
        if (o !== e) begin n_err++; $display("FAIL ext_up_beat%0d got %0d want %0d", i, o, e); end
      end
    end
    extreme_leg(32'sh7FFF_FFFF, 32'sh8000_0000, 32'h7000_0000, "ext_down");
    extreme_leg(32'sh8000_0000, 32'sh7FFF_FFFF, 32'hFFFF_FFFF, "ext_jump");
  endtask

  task automatic test_retarget();
    bit found;
    do_reset();
    cfg_step = 32'd100; cfg_prescale = 16'd3;
    exp_q.push_back(32'sd100);
    exp_q.push_back(32'sd200);
    exp_q.push_back(32'sd100);
    exp_q.push_back(32'sd0);
    exp_q.push_back(-32'sd100);
    exp_q.push_back(-32'sd100);
    s_tdata = 32'sd500; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      if (m_tvalid && m_tdata == 32'sd200) found = 1'b1; else step_cyc();
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rt_reach200 got timeout want beat 200"); end
    s_tdata = -32'sd100; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    wait_beats(6, 100);
    for (int i = 0; i < 6; i++) begin
      logic signed [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_data.size() == 0) begin n_err++; $display("FAIL rt_beat%0d got none (timeout) want %0d", i, e); end
      else begin
        logic signed [31:0] o;
        o = obs_data.pop_front();
        if (o !== e) begin n_err++; $display("FAIL rt_beat%0d got %0d want %0d", i, o, e); end
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    bit found;
    logic signed [31:0] c;
    do_reset();
    cfg_step = 32'd100; cfg_prescale = 16'd0;
    s_tdata = 32'sd1000; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 50 && !found; t++) begin
      if (m_tvalid && m_tdata == 32'sd300) found = 1'b1; else step_cyc();
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL mr_reach300 got timeout want beat 300"); end
    aresetn = 1'b0;
    step_cyc();
    aresetn = 1'b1;
    n_cmp++; if (m_tvalid !== 1'b0 || m_tdata !== 32'sd0) begin n_err++; $display("FAIL mr_out_cleared got v=%b d=%0d want v=0 d=0", m_tvalid, m_tdata); end
    n_cmp++; if (busy !== 1'b0 || at_tgt !== 1'b0) begin n_err++; $display("FAIL mr_sts_cleared got busy=%b at=%b want 0 0", busy, at_tgt); end
    obs_data.delete();
    obs_cyc.delete();
    for (int i = 0; i < 6; i++) step_cyc();
    n_cmp++; if (obs_data.size() !== 0 || m_tvalid !== 1'b0) begin n_err++; $display("FAIL mr_no_beats got %0d beats v=%b want 0 beats v=0", obs_data.size(), m_tvalid); end
    c = 0;
    for (int i = 0; i < 3; i++) begin c = model_next(c, 32'sd250, 100); exp_q.push_back(c); end
    s_tdata = 32'sd250; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    wait_beats(3, 50);
    for (int i = 0; i < 3; i++) begin
      logic signed [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_data.size() == 0) begin n_err++; $display("FAIL mr_beat%0d got none (timeout) want %0d", i, e); end
      else begin
        logic signed [31:0] o;
        o = obs_data.pop_front();
        if (o !== e) begin n_err++; $display("FAIL mr_beat%0d got %0d want %0d", i, o, e); end
      end
    end
  endtask

  task automatic test_step_zero();
    logic signed [31:0] c;
    do_reset();
    cfg_step = 32'd0; cfg_prescale = 16'd0;
    c = 0;
    for (int i = 0; i < 4; i++) begin c = model_next(c, 32'sd77, 0); exp_q.push_back(c); end
    s_tdata = 32'sd77; s_tvalid = 1'b1;
    step_cyc();
    s_tvalid = 1'b0;
    wait_beats(4, 50);
    for (int i = 0; i < 4; i++) begin
      logic signed [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_data.size() == 0) begin n_err++; $display("FAIL zero_beat%0d got none (timeout) want %0d", i, e); end
      else begin
        logic signed [31:0] o;
        o = obs_data.pop_front();
        if (o !== e) begin n_err++; $display("FAIL zero_beat%0d got %0d want %0d", i, o, e); end
      end
    end
    n_cmp++; if (busy !== 1'b1 || at_tgt !== 1'b0) begin n_err++; $display("FAIL zero_sts got busy=%b at=%b want busy=1 at=0", busy, at_tgt); end
  endtask

  initial begin
    aresetn      = 1'b0;
    s_tvalid     = 1'b0;
    s_tdata      = '0;
    m_tready     = 1'b1;
    cfg_step     = '0;
    cfg_prescale = '0;
    #1;
    test_reset();
    test_basic_ramp();
    test_prescale();
    test_backpressure();
    test_retarget();
    test_extremes();
    test_reset_mid_ramp();
    test_step_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_axis_slew_limiter
`default_nettype wire
